// File: rtl/cs_pkg.sv
// Shared definitions for the Mini SRC hardwired control sequencer:
// state encoding, opcode map, ALU codes and MDR source selects.
package cs_pkg;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    localparam logic [1:0] MDR_BUS = 2'b00;
    localparam logic [1:0] MDR_MEM = 2'b01;

    // ALU operation for the arithmetic/logic opcodes (register and immediate forms).
    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: alu_code = ALU_ADD;
            OP_SUB:          alu_code = ALU_SUB;
            OP_OR, OP_ORI:   alu_code = ALU_OR;
            default:         alu_code = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC datapath: 3-cycle fetch followed by
// an opcode-dependent execute sequence, with stop/halt and run status.
module control_sequencer
    import cs_pkg::*;
#(
    parameter int OPW             = 5,
    parameter int ALUW            = 4,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stop,
    input  logic [31:0]     IR,
    input  logic            CON,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            MARin,
    output logic            Zlowin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            IncPc,
    output logic            read,
    output logic            write,
    output logic [1:0]      mdr_read,
    output logic [ALUW-1:0] control,
    output logic            Cout,
    output logic            BAout,
    output logic            Rin,
    output logic            Rout,
    output logic            GRA,
    output logic            GRB,
    output logic            GRC,
    output logic            CONin,
    output logic            run,
    output logic            illegal,
    output logic [3:0]      dbg_state
);

    state_t          state, next_state, done_state;
    logic [OPW-1:0]  op_q, op;
    logic            unused_ir;

    // Opcode is taken live in T3 (IR just loaded) and held for the rest of execute.
    assign op         = (state == T3) ? IR[31 -: OPW] : op_q;
    assign done_state = stop ? HALT : T0;
    assign dbg_state  = state;
    assign unused_ir  = ^IR[31-OPW:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
            op_q  <= '0;
        end else begin
            state <= next_state;
            if (state == T3) op_q <= IR[31 -: OPW];
        end
    end

    always_comb begin
        next_state = state;
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0; Zlowin = 1'b0;
        PCin  = 1'b0; MDRin   = 1'b0; IRin   = 1'b0; Yin   = 1'b0; IncPc  = 1'b0;
        read  = 1'b0; write   = 1'b0; mdr_read = MDR_BUS; control = '0;
        Cout  = 1'b0; BAout   = 1'b0; Rin    = 1'b0; Rout  = 1'b0;
        GRA   = 1'b0; GRB     = 1'b0; GRC    = 1'b0; CONin = 1'b0;
        run   = (state != RST) && (state != HALT);
        illegal = 1'b0;

        case (state)
            RST: next_state = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
                next_state = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; mdr_read = MDR_MEM; MDRin = 1'b1;
                next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST: begin
                        GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; next_state = T4;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; next_state = T4;
                    end
                    OP_BR: begin
                        GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; next_state = T4;
                    end
                    OP_NOP:  next_state = done_state;
                    OP_HALT: next_state = HALT;
                    default: begin
                        illegal    = 1'b1;
                        next_state = (HALT_ON_ILLEGAL != 0) ? HALT : done_state;
                    end
                endcase
            end
            T4: begin
                next_state = T5;
                case (op)
                    OP_LD, OP_LDI, OP_ST: begin
                        Cout = 1'b1; control = ALUW'(ALU_ADD); Zlowin = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        GRC = 1'b1; Rout = 1'b1; control = ALUW'(alu_code(op)); Zlowin = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        Cout = 1'b1; control = ALUW'(alu_code(op)); Zlowin = 1'b1;
                    end
                    OP_BR: begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                    default: next_state = T0;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; next_state = done_state;
                    end
                    OP_LD, OP_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1; next_state = T6;
                    end
                    OP_BR: begin
                        Cout = 1'b1; control = ALUW'(ALU_ADD); Zlowin = 1'b1; next_state = T6;
                    end
                    default: next_state = T0;
                endcase
            end
            T6: begin
                case (op)
                    OP_LD: begin
                        read = 1'b1; mdr_read = MDR_MEM; MDRin = 1'b1; next_state = T7;
                    end
                    OP_ST: begin
                        GRA = 1'b1; Rout = 1'b1; mdr_read = MDR_BUS; MDRin = 1'b1; next_state = T7;
                    end
                    OP_BR: begin
                        Zlowout = 1'b1; PCin = CON; next_state = done_state;
                    end
                    default: next_state = T0;
                endcase
            end
            T7: begin
                if (op == OP_LD) begin
                    MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                end else if (op == OP_ST) begin
                    write = 1'b1;
                end
                next_state = done_state;
            end
            HALT:    next_state = HALT;
            default: next_state = RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: two instances (illegal-as-nop and
// illegal-halts) share stimulus and are checked against a per-cycle strobe table.
module tb_control_sequencer;

    typedef struct packed {
        logic       pc_out, zlow_out, mdr_out, mar_in, zlow_in, pc_in, mdr_in, ir_in, y_in, inc_pc;
        logic       rd, wr;
        logic [1:0] mdr_sel;
        logic [3:0] ctl;
        logic       c_out, ba_out, r_in, r_out, gra, grb, grc, con_in, run, illegal;
    } sig_t;

    localparam int W = $bits(sig_t);

    localparam int C_LD = 0, C_LDI = 1, C_ST = 2, C_RT = 3, C_IMM = 4;
    localparam int C_BR = 5, C_NOP = 6, C_HALT = 7, C_ILL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stop = 1'b0;
    logic        CON = 1'b0;
    logic [31:0] IR = '0;
    wire sig_t   o0, o1;
    wire [3:0]   st0, st1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    control_sequencer #(.OPW(5), .ALUW(4), .HALT_ON_ILLEGAL(0)) u_dut0 (
        .clk(clk), .reset(reset), .stop(stop), .IR(IR), .CON(CON),
        .PCout(o0.pc_out), .Zlowout(o0.zlow_out), .MDRout(o0.mdr_out), .MARin(o0.mar_in),
        .Zlowin(o0.zlow_in), .PCin(o0.pc_in), .MDRin(o0.mdr_in), .IRin(o0.ir_in),
        .Yin(o0.y_in), .IncPc(o0.inc_pc), .read(o0.rd), .write(o0.wr),
        .mdr_read(o0.mdr_sel), .control(o0.ctl), .Cout(o0.c_out), .BAout(o0.ba_out),
        .Rin(o0.r_in), .Rout(o0.r_out), .GRA(o0.gra), .GRB(o0.grb), .GRC(o0.grc),
        .CONin(o0.con_in), .run(o0.run), .illegal(o0.illegal), .dbg_state(st0)
    );

    control_sequencer #(.OPW(5), .ALUW(4), .HALT_ON_ILLEGAL(1)) u_dut1 (
        .clk(clk), .reset(reset), .stop(stop), .IR(IR), .CON(CON),
        .PCout(o1.pc_out), .Zlowout(o1.zlow_out), .MDRout(o1.mdr_out), .MARin(o1.mar_in),
        .Zlowin(o1.zlow_in), .PCin(o1.pc_in), .MDRin(o1.mdr_in), .IRin(o1.ir_in),
        .Yin(o1.y_in), .IncPc(o1.inc_pc), .read(o1.rd), .write(o1.wr),
        .mdr_read(o1.mdr_sel), .control(o1.ctl), .Cout(o1.c_out), .BAout(o1.ba_out),
        .Rin(o1.r_in), .Rout(o1.r_out), .GRA(o1.gra), .GRB(o1.grb), .GRC(o1.grc),
        .CONin(o1.con_in), .run(o1.run), .illegal(o1.illegal), .dbg_state(st1)
    );

    // ---------------- reference model ----------------
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'b00000: return C_LD;
            5'b00001: return C_LDI;
            5'b00010: return C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_RT;
            5'b01100, 5'b01101, 5'b01110: return C_IMM;
            5'b10010: return C_BR;
            5'b11010: return C_NOP;
            5'b11011: return C_HALT;
            default:  return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01100: return 4'd2;
            5'b00100:           return 4'd3;
            5'b00101, 5'b01101: return 4'd0;
            default:            return 4'd1;
        endcase
    endfunction

    function automatic int exec_len(input logic [4:0] op);
        case (op_class(op))
            C_LD, C_ST:         return 5;
            C_LDI, C_RT, C_IMM: return 3;
            C_BR:               return 4;
            default:            return 1;
        endcase
    endfunction

    function automatic sig_t fetch_vec(input int t);
        sig_t s = '0;
        s.run = 1'b1;
        if (t == 0) begin s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.zlow_in = 1; end
        if (t == 1) begin s.zlow_out = 1; s.pc_in = 1; s.rd = 1; s.mdr_sel = 2'b01; s.mdr_in = 1; end
        if (t == 2) begin s.mdr_out = 1; s.ir_in = 1; end
        return s;
    endfunction

    function automatic sig_t exec_vec(input logic [4:0] op, input int k, input logic con);
        sig_t s = '0;
        int cls = op_class(op);
        s.run = 1'b1;
        if (cls == C_LD || cls == C_LDI || cls == C_ST) begin
            if (k == 0) begin s.grb = 1; s.ba_out = 1; s.y_in = 1; end
            if (k == 1) begin s.c_out = 1; s.ctl = 4'd2; s.zlow_in = 1; end
        end
        if ((cls == C_LD || cls == C_ST) && k == 2) begin s.zlow_out = 1; s.mar_in = 1; end
        if (cls == C_LD && k == 3) begin s.rd = 1; s.mdr_sel = 2'b01; s.mdr_in = 1; end
        if (cls == C_LD && k == 4) begin s.mdr_out = 1; s.gra = 1; s.r_in = 1; end
        if (cls == C_ST && k == 3) begin s.gra = 1; s.r_out = 1; s.mdr_sel = 2'b00; s.mdr_in = 1; end
        if (cls == C_ST && k == 4) s.wr = 1;
        if (cls == C_RT || cls == C_IMM) begin
            if (k == 0) begin s.grb = 1; s.r_out = 1; s.y_in = 1; end
            if (k == 1) begin
                if (cls == C_RT) begin s.grc = 1; s.r_out = 1; end
                else s.c_out = 1;
                s.ctl = alu_of(op); s.zlow_in = 1;
            end
        end
        if ((cls == C_LDI || cls == C_RT || cls == C_IMM) && k == 2) begin
            s.zlow_out = 1; s.gra = 1; s.r_in = 1;
        end
        if (cls == C_BR) begin
            if (k == 0) begin s.gra = 1; s.r_out = 1; s.con_in = 1; end
            if (k == 1) begin s.pc_out = 1; s.y_in = 1; end
            if (k == 2) begin s.c_out = 1; s.ctl = 4'd2; s.zlow_in = 1; end
            if (k == 3) begin s.zlow_out = 1; s.pc_in = con; end
        end
        if (cls == C_ILL && k == 0) s.illegal = 1;
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input int dut, input logic [W-1:0] obs);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, dut, obs, e);
        end
    endtask

    task automatic check_both(input string tag, input sig_t e0, input sig_t e1);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        check(tag, 0, o0);
        check(tag, 1, o1);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        stop  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check_both("rst", '0, '0);
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ir_v, input logic con_br, input logic stop_fin,
                             input int abort_at, output bit halted0, output bit halted1);
        logic [4:0] op;
        int         n;
        sig_t       e;
        op = ir_v[31:27];
        n  = 3 + exec_len(op);
        halted0 = 1'b0;
        halted1 = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            IR   = ir_v;
            stop = (c == n - 1) ? stop_fin : 1'($urandom_range(0, 1));
            CON  = (op_class(op) == C_BR && c == 6) ? con_br : 1'($urandom_range(0, 1));
            #1;
            e = (c < 3) ? fetch_vec(c) : exec_vec(op, c - 3, CON);
            check_both($sformatf("op%b_c%0d", op, c), e, e);
            if (c == abort_at) return;
        end
        halted0 = (op_class(op) == C_HALT) || stop_fin;
        halted1 = halted0 || (op_class(op) == C_ILL);
    endtask

    // Two cycles after an instruction: halted instances stay dark, others start fetch.
    task automatic post_check(input bit h0, input bit h1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            IR   = $urandom();
            stop = 1'($urandom_range(0, 1));
            CON  = 1'($urandom_range(0, 1));
            #1;
            check_both($sformatf("post_c%0d", c), h0 ? sig_t'('0) : fetch_vec(c),
                       h1 ? sig_t'('0) : fetch_vec(c));
        end
    endtask

    task automatic do_instr(input logic [31:0] ir_v, input logic con_br, input logic stop_fin);
        bit h0, h1;
        run_instr(ir_v, con_br, stop_fin, -1, h0, h1);
        if (h0 || h1) begin
            post_check(h0, h1);
            do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h0, h1;
        logic [4:0] ops[16];
        logic [31:0] r;
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b11010, 5'b11011,
                5'b11111, 5'b00111, 5'b10000};

        do_reset();

        do_instr(32'h0880_0055, 1'b0, 1'b0);
        do_instr(32'h1100_0000, 1'b0, 1'b0);
        do_instr(32'h9000_0004, 1'b0, 1'b0);
        do_instr(32'h9000_0004, 1'b1, 1'b0);

        run_instr(32'h0880_0055, 1'b0, 1'b0, 3, h0, h1);
        do_reset();

        do_instr(32'hF800_0000, 1'b0, 1'b0);
        do_instr(32'h1800_0000, 1'b0, 1'b1);
        do_instr(32'hD800_0000, 1'b0, 1'b0);
        do_instr(32'h0000_0000, 1'b0, 1'b0);
        do_instr(32'h6000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            do_instr({ops[$urandom_range(0, 15)], r[26:0]}, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the Mini SRC datapath (dataPath).
- Generates every per-cycle control strobe that bench stimulus currently drives by hand: a 3-cycle fetch (T0-T2), then an opcode-dependent execute sequence (T3-T7).
- Sits beside dataPath. Reads IR and CON from it; drives its control inputs.
- Supports stop/halt and run status.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALUW, 4, width of ALU control code.
- HALT_ON_ILLEGAL, 0, 1 = illegal opcode enters HALT; 0 = treated as nop.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- stop  in  1  level; halt after the current instruction completes.
- IR  in  32  instruction register value from dataPath.
- CON  in  1  branch condition flag from dataPath CON-FF.
- PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPc  out  1 each  datapath strobes.
- read, write  out  1 each  memory strobes.
- mdr_read  out  2  MDR mux select: 00 = bus, 01 = memory.
- control  out  ALUW  ALU operation code.
- Cout, BAout, Rin, Rout, GRA, GRB, GRC, CONin  out  1 each  select/encode strobes.
- run  out  1  high while executing instructions.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- State register updates on posedge clk. Outputs are a combinational decode of state (plus IR/CON where noted) and are valid for the whole cycle; dataPath samples them at the next posedge.
- States: RST, T0..T7, HALT.
- reset (any state, mid-instruction included) -> RST on next edge.
- RST: all outputs 0, run = 0. Next state T0.
- Fetch:
  - T0: PCout, MARin, IncPc, Zlowin.
  - T1: Zlowout, PCin, read, mdr_read = 01, MDRin.
  - T2: MDRout, IRin.
  - The IR update at the end of T2 is visible in T3. Dispatch uses IR[31:27] sampled in T3.
- Execute sequences (strobes not listed are 0; control defaults to 0):
  - ldi (00001): T3 GRB, BAout, Yin | T4 Cout, control = ADD, Zlowin | T5 Zlowout, GRA, Rin.
  - ld (00000): T3-T4 as ldi | T5 Zlowout, MARin | T6 read, mdr_read = 01, MDRin | T7 MDRout, GRA, Rin.
  - st (00010): T3-T4 as ldi | T5 Zlowout, MARin | T6 GRA, Rout, mdr_read = 00, MDRin | T7 write.
  - R-type add/sub/and/or (00011/00100/00101/00110): T3 GRB, Rout, Yin | T4 GRC, Rout, control = op, Zlowin | T5 Zlowout, GRA, Rin.
  - addi/andi/ori (01100/01101/01110): T3 GRB, Rout, Yin | T4 Cout, control = op, Zlowin | T5 Zlowout, GRA, Rin.
  - br (10010): T3 GRA, Rout, CONin | T4 PCout, Yin | T5 Cout, control = ADD, Zlowin | T6 Zlowout, PCin = CON.
  - nop (11010): T3 no strobes.
  - halt (11011): T3 no strobes, then HALT.
- After the last execute state: next = HALT if stop is high, else T0. stop is sampled only in the final execute state.
- HALT: all strobes 0, run = 0. Held until reset.
- Illegal opcode: illegal = 1 during T3.
  - HALT_ON_ILLEGAL = 0: behaves as nop.
  - HALT_ON_ILLEGAL = 1: next state HALT.
- Write and read are never both high. IncPc is only asserted with PCout.
- run = 1 in T0..T7.

Decomposition:
- Package cs_pkg holds:
  - state enum (RST, T0..T7, HALT);
  - opcode constants (LD, LDI, ST, ADD, SUB, AND, OR, ADDI, ANDI, ORI, BR, NOP, HALT);
  - ALU codes (AND = 0, OR = 1, ADD = 2, SUB = 3);
  - mdr_read encodings.
- No sub-module. One state-register process plus one output-decode process.

Test Plan:
- Reset mid-T4 of ldi -> next cycle state RST, all strobes 0; two cycles later T0 with PCout = MARin = IncPc = Zlowin = 1.
- IR = 0x0880_0055 (ldi r1, 85) -> T0-T2 fetch strobes as specified; T3 GRB/BAout/Yin; T4 Cout, control = 2; T5 GRA/Rin; T0 recurs at cycle 6; with dataPath, R1 = 85.
- IR = 0x1100_0000 (st r2, 0(r0)) -> T6 mdr_read = 00, MDRin; T7 write = 1, read = 0; back to T0 after 8 cycles.
- IR = 0x9000_0004 (br), CON = 0 then CON = 1 -> T6 PCin = 0 / PCin = 1 respectively.
- IR opcode 11111, HALT_ON_ILLEGAL = 0 -> illegal pulse in T3, next T0. With HALT_ON_ILLEGAL = 1 -> HALT, run = 0.
- stop raised during T4 of an add -> instruction completes through T5, then HALT, run = 0. Halt opcode behaves the same with stop = 0.
